lmfe_win_feeder: RTL and testbench
==================================

Name: lmfe_win_feeder

Overview:
- Frame-level sequencer that drives the 49-entry running-median engine (7x7 window) for the local median filter.
- Raster-scans the image from the input image RAM and generates the INS/DEL/SEN pair stream the engine consumes.
- Captures the engine's MED result once per pixel and writes it to the output result RAM.
- Sits between the image RAM read port and the median engine; the median engine and this block share clk/RST.

Parameters:
- IMG_W, 8, image width in pixels (>=1)
- IMG_H, 8, image height in pixels (>=1)
- AW, 6, RAM address width; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
- clk  in  1  clock
- RST  in  1  reset, asynchronous, active-high; shared with the median engine
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result write
- ram_rd  out  1  image RAM read strobe
- ram_addr  out  AW  image RAM address = row*IMG_W+col
- ram_q  in  8  image RAM data, valid exactly 1 cycle after ram_rd
- sen  out  1  engine hold: 1 = no pair (engine sees INS=DEL=255)
- ins  out  8  pixel inserted into the engine
- del  out  8  pixel removed from the engine
- med  in  8  engine median output (25th smallest)
- out_we  out  1  result RAM write strobe
- out_addr  out  AW  result address = row*IMG_W+col
- out_data  out  8  median value

Behaviour:
Reset state:
- busy=0, done=0, ram_rd=0, sen=1, ins=del=8'hFF, out_we=0, out_addr=0, out_data=0, FSM=IDLE.
- All 49 window shadow-buffer entries = 8'hFF, mirroring the engine's all-FF reset content.

Window shadow buffer:
- 7 column slots x 7 rows; a circular column pointer marks the oldest slot.
- Every pair has the form INS = new pixel, DEL = the shadow entry it replaces. That entry is overwritten with INS in the same cycle.
- The shadow buffer therefore always equals the engine's 49-value multiset.

Padding:
- Coordinates outside 0..IMG_W-1 / 0..IMG_H-1 issue no RAM read (ram_rd=0); the pixel value is 8'h00.
- The pair slot is still consumed, so pair timing is identical to in-image positions.

FSM:
- IDLE: start=1 -> FILL with row=0, col=0. start is ignored while busy.
- FILL (col=0 of each row): 49 issue cycles, column-major order dc=-3..+3 outer, dr=-3..+3 inner. Replaces all 49 shadow entries (flushes the previous row's window) -> WAIT.
- SLIDE (col>0): 7 issue cycles for column col+3, dr=-3..+3. Replaces the oldest column slot, then advances the pointer -> WAIT.
- WAIT: drains the read pipeline, then captures med -> WRITE.
- WRITE: out_we=1 for one cycle.
  - col<IMG_W-1 -> SLIDE with col+1.
  - else row<IMG_H-1 -> FILL with row+1, col=0.
  - else -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.

Pipeline timing:
- Issue at cycle c (ram_rd/ram_addr).
- ram_q at c+1.
- ins/del registered with sen=0 at c+2.
- Engine updates at the end of c+2.
- For the last pair of a pixel at cycle t: med valid at t+1, sampled into out_data at t+1, out_we=1 at t+2.
- sen=0 only in cycles carrying a pair; otherwise sen=1, ins=del=FF.
- Issues are back-to-back with no bubbles inside FILL/SLIDE.

Throughput:
- Per pixel: 49+4 cycles (FILL) or 7+4 cycles (SLIDE).
- out_we never overlaps pair cycles.

Reset mid-frame:
- All state returns to reset values immediately.
- The engine resets on the same RST, so the shadow and engine stay consistent.
- No further writes occur until a new start.

Arithmetic:
- Signed coordinates use 1 extra bit for the -3 and +3 excursions.
- Address = row*IMG_W+col truncated to AW bits, computed only for in-range coordinates.

Optional Feature:
- LMFE_BORDER_REPLICATE_EN defined: out-of-range coordinates clamp to the nearest edge (0 or IMG_W-1 / IMG_H-1), and a RAM read is issued for the clamped address.
- Undefined: zero padding as specified above.
- Pair count and timing are identical either way.

Test Plan:
1. Reset check: assert RST mid-frame, release it -> busy=0, sen=1, ins=del=FF, out_we=0. A following start produces a correct full frame.
2. 8x8 constant image 0x40, zero pad:
   - out(0,0)=0x00 (16 valid pixels of 49).
   - out(0,3)=0x40 (28 valid).
   - out(3,3)=0x40.
   - 64 writes total, then one done pulse.
3. 8x8 ramp, pixel=8*row+col: interior out(3,3)=27 and out(4,4)=36. out_addr equals row*8+col in strict raster order.
4. Pair stream:
   - Row 0 col 0: 49 pairs, all del=FF.
   - Row 0 col 1: 7 pairs, del = column -3 values (0x00).
   - Row 1 col 0: del values equal the row-0 last-window contents.
   - out_we lands exactly 2 cycles after the last sen=0.
5. start pulses while busy -> ignored. Frame length matches 8*(53) + 8*7*(11) + 1 cycles.
6. With LMFE_BORDER_REPLICATE_EN on the constant 0x40 image -> every output 0x40, including corners; no ram_addr ever exceeds 63.

Source files
------------

// File: rtl/lmfe_win_feeder.sv
// lmfe_win_feeder: frame sequencer for the 7x7 running-median engine.
//
// Raster-scans the image RAM and feeds the engine one INS/DEL pair per cycle.
// A 7x7 shadow copy of the engine contents supplies each DEL value. The block
// captures MED once per pixel and writes it to the result RAM.
//
// Ports:
//   clk, RST           clock, asynchronous active-high reset (shared with engine)
//   start              one-cycle pulse, starts a frame when idle
//   busy, done         frame in progress / one-cycle end-of-frame pulse
//   ram_rd, ram_addr   image RAM read strobe and address (row*IMG_W+col)
//   ram_q              image RAM data, valid one cycle after ram_rd
//   sen, ins, del      engine pair stream (sen=1: hold, ins=del=FF)
//   med                engine median output
//   out_we, out_addr,  result RAM write port
//   out_data
//
// Build option: define LMFE_BORDER_REPLICATE_EN to clamp out-of-image
// coordinates to the nearest edge instead of zero padding.
module lmfe_win_feeder #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ram_rd,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_q,
    output logic          sen,
    output logic [7:0]    ins,
    output logic [7:0]    del,
    input  logic [7:0]    med,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_data
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    // Signed coordinate width: room for the -3 / +3 window excursions.
    localparam int unsigned XW = ((CW > RW) ? CW : RW) + 3;

    typedef enum logic [2:0] {StIdle, StFill, StSlide, StWait, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    dc_idx_q, dc_idx_d;
    logic [2:0]    dr_idx_q, dr_idx_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [1:0]    wait_q, wait_d;

    logic                 issuing, rd_en, in_x, in_y;
    logic signed [XW-1:0] cx, ry;
    logic [XW-1:0]        cx_c, ry_c;
    logic [3:0]           fill_sum;
    logic [2:0]           slot;

    // Read-pipeline stage: one pair in flight between issue and ins/del.
    logic       p1_vld_q, p1_pad_q;
    logic [2:0] p1_slot_q, p1_dr_q;
    logic [7:0] shadow_q [7][7];
    logic [7:0] pix;

    assign issuing = (state_q == StFill) || (state_q == StSlide);
    assign busy    = (state_q != StIdle) && (state_q != StDone);
    assign done    = (state_q == StDone);
    assign out_we  = (state_q == StWrite);

    always_comb begin
        cx   = $signed(XW'(col_q) + XW'(dc_idx_q)) - $signed(XW'(3));
        ry   = $signed(XW'(row_q) + XW'(dr_idx_q)) - $signed(XW'(3));
        in_x = !cx[XW-1] && (cx < $signed(XW'(IMG_W)));
        in_y = !ry[XW-1] && (ry < $signed(XW'(IMG_H)));
`ifdef LMFE_BORDER_REPLICATE_EN
        if (cx[XW-1])  cx_c = '0;
        else if (!in_x) cx_c = XW'(IMG_W - 1);
        else            cx_c = cx;
        if (ry[XW-1])  ry_c = '0;
        else if (!in_y) ry_c = XW'(IMG_H - 1);
        else            ry_c = ry;
        rd_en = issuing;
`else
        cx_c  = cx;
        ry_c  = ry;
        rd_en = issuing && in_x && in_y;
`endif
        ram_rd   = rd_en;
        ram_addr = rd_en ? (AW'(ry_c) * AW'(IMG_W) + AW'(cx_c)) : '0;
        // FILL lays dc=-3..+3 onto slots ptr..ptr+6, so ptr stays the oldest column.
        fill_sum = {1'b0, ptr_q} + {1'b0, dc_idx_q};
        if (state_q == StSlide)     slot = ptr_q;
        else if (fill_sum >= 4'd7)  slot = 3'(fill_sum - 4'd7);
        else                        slot = fill_sum[2:0];
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        dc_idx_d = dc_idx_q;
        dr_idx_d = dr_idx_q;
        ptr_d    = ptr_q;
        wait_d   = wait_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StFill;
                    row_d    = '0;
                    col_d    = '0;
                    dc_idx_d = 3'd0;
                    dr_idx_d = 3'd0;
                end
            end
            StFill: begin
                if (dr_idx_q == 3'd6) begin
                    dr_idx_d = 3'd0;
                    dc_idx_d = dc_idx_q + 3'd1;
                    if (dc_idx_q == 3'd6) begin
                        state_d = StWait;
                        wait_d  = 2'd0;
                    end
                end else begin
                    dr_idx_d = dr_idx_q + 3'd1;
                end
            end
            StSlide: begin
                if (dr_idx_q == 3'd6) begin
                    dr_idx_d = 3'd0;
                    ptr_d    = (ptr_q == 3'd6) ? 3'd0 : ptr_q + 3'd1;
                    state_d  = StWait;
                    wait_d   = 2'd0;
                end else begin
                    dr_idx_d = dr_idx_q + 3'd1;
                end
            end
            // Two cycles for the last pair to reach the engine, third samples med.
            StWait: begin
                wait_d = wait_q + 2'd1;
                if (wait_q == 2'd2) state_d = StWrite;
            end
            StWrite: begin
                dr_idx_d = 3'd0;
                if (col_q < CW'(IMG_W - 1)) begin
                    state_d  = StSlide;
                    col_d    = col_q + 1'b1;
                    dc_idx_d = 3'd6;
                end else if (row_q < RW'(IMG_H - 1)) begin
                    state_d  = StFill;
                    row_d    = row_q + 1'b1;
                    col_d    = '0;
                    dc_idx_d = 3'd0;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            dc_idx_q <= 3'd0;
            dr_idx_q <= 3'd0;
            ptr_q    <= 3'd0;
            wait_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dc_idx_q <= dc_idx_d;
            dr_idx_q <= dr_idx_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
        end
    end

    assign pix = p1_pad_q ? 8'h00 : ram_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            p1_vld_q  <= 1'b0;
            p1_pad_q  <= 1'b0;
            p1_slot_q <= 3'd0;
            p1_dr_q   <= 3'd0;
            sen       <= 1'b1;
            ins       <= 8'hFF;
            del       <= 8'hFF;
            out_addr  <= '0;
            out_data  <= 8'h00;
            for (int s = 0; s < 7; s++) begin
                for (int r = 0; r < 7; r++) begin
                    shadow_q[s][r] <= 8'hFF;
                end
            end
        end else begin
            p1_vld_q  <= issuing;
            p1_pad_q  <= !rd_en;
            p1_slot_q <= slot;
            p1_dr_q   <= dr_idx_q;
            if (p1_vld_q) begin
                sen                          <= 1'b0;
                ins                          <= pix;
                del                          <= shadow_q[p1_slot_q][p1_dr_q];
                shadow_q[p1_slot_q][p1_dr_q] <= pix;
            end else begin
                sen <= 1'b1;
                ins <= 8'hFF;
                del <= 8'hFF;
            end
            if (state_q == StWait && wait_q == 2'd2) begin
                out_data <= med;
                out_addr <= AW'(row_q) * AW'(IMG_W) + AW'(col_q);
            end
        end
    end

endmodule

// File: tb/tb_lmfe_win_feeder.sv
module tb_lmfe_win_feeder;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, ram_rd, sen, out_we;
    logic [5:0] ram_addr, out_addr;
    logic [7:0] ram_q, ins, del, med, out_data;

    lmfe_win_feeder #(.IMG_W(W), .IMG_H(H), .AW(6)) dut (
        .clk      (clk),
        .RST      (RST),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .sen      (sen),
        .ins      (ins),
        .del      (del),
        .med      (med),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] img [64];
    logic [7:0] res [64];

    // Image RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_rd) ram_q <= img[ram_addr];
    end

    // Behavioural median engine: multiset histogram, 25th smallest.
    int eng_cnt [256];
    int eng_err = 0;
    always @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int v = 0; v < 256; v++) eng_cnt[v] = 0;
            eng_cnt[255] = 49;
            med <= 8'hFF;
        end else if (!sen) begin
            int acc;
            logic [7:0] m;
            logic found;
            if (eng_cnt[del] == 0) eng_err = eng_err + 1;
            else eng_cnt[del] = eng_cnt[del] - 1;
            eng_cnt[ins] = eng_cnt[ins] + 1;
            acc = 0;
            found = 1'b0;
            m = 8'h00;
            for (int v = 0; v < 256; v++) begin
                acc = acc + eng_cnt[v];
                if (!found && acc >= 25) begin
                    m = 8'(v);
                    found = 1'b1;
                end
            end
            med <= m;
        end
    end

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         sel;  // 0 = constant 0x40, 1 = ramp
        int         r;
        int         c;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[10];

    logic [7:0] pdel[$];
    logic [7:0] pins[$];
    int cyc = 0, last_pair = -100, nwrites = 0, ndone = 0, nreads = 0;
    int busy_start = 0, frame_len = 0;
    logic busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix_at(input int r, input int c);
`ifdef LMFE_BORDER_REPLICATE_EN
        int rr = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
        int cc = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
        return img[rr * W + cc];
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 8'h00;
        return img[r * W + c];
`endif
    endfunction

    function automatic logic [7:0] exp_med(input int r, input int c);
        logic [7:0] v [49];
        logic [7:0] t;
        int k = 0;
        for (int dr = -3; dr <= 3; dr++)
            for (int dc = -3; dc <= 3; dc++) begin
                v[k] = pix_at(r + dr, c + dc);
                k++;
            end
        for (int i = 0; i < 48; i++)
            for (int j = 0; j < 48 - i; j++)
                if (v[j] > v[j + 1]) begin
                    t = v[j]; v[j] = v[j + 1]; v[j + 1] = t;
                end
        return v[24];
    endfunction

    function automatic int in_img(input int r, input int c);
        return (r >= 0 && r < H && c >= 0 && c < W) ? 1 : 0;
    endfunction

    function automatic int exp_reads();
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (c == 0) begin
                    for (int dc = -3; dc <= 3; dc++)
                        for (int dr = -3; dr <= 3; dr++)
`ifdef LMFE_BORDER_REPLICATE_EN
                            n++;
`else
                            n += in_img(r + dr, c + dc);
`endif
                end else begin
                    for (int dr = -3; dr <= 3; dr++)
`ifdef LMFE_BORDER_REPLICATE_EN
                        n++;
`else
                        n += in_img(r + dr, c + 3);
`endif
                end
        return n;
    endfunction

    task automatic set_img(input int sel);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r * W + c] = (sel == 0) ? 8'h40 : 8'(8 * r + c);
    endtask

    task automatic mon_step();
        exp_t e;
        cyc++;
        if (busy && !busy_prev) busy_start = cyc;
        busy_prev = busy;
        if (ram_rd) nreads++;
        if (!sen) begin
            pdel.push_back(del);
            pins.push_back(ins);
            last_pair = cyc;
        end
        if (out_we) begin
            nwrites++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(out_addr), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("out_addr", 32'(out_addr), 32'(e.addr));
                chk("out_data", 32'(out_data), 32'(e.data));
            end
            res[out_addr] = out_data;
            chk("we_after_last_pair", 32'(cyc - last_pair), 32'd2);
        end
        if (done) begin
            ndone++;
            frame_len = cyc - busy_start + 1;
        end
    endtask

    task automatic clear_stats();
        pdel.delete();
        pins.delete();
        nwrites = 0;
        ndone   = 0;
        nreads  = 0;
    endtask

    task automatic run_frame(input int sel, input bit spam);
        int n = 0;
        int d0 = ndone;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                exp_t e;
                e.addr = 6'(r * W + c);
                e.data = exp_med(r, c);
                sb.push_back(e);
            end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (ndone == d0 && n < 5000) begin
            @(negedge clk);
            n++;
            start = (spam && (n == 100 || n == 500 || n == 900)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("frame_finished", 32'(n < 5000), 32'd1);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 10; i++)
            if (vt[i].sel == sel)
                chk($sformatf("spot_%0d_%0d_%0d", sel, vt[i].r, vt[i].c),
                    32'(res[vt[i].r * W + vt[i].c]), 32'(vt[i].exp));
    endtask

    initial begin
        int ha [256];
        int hb [256];
        int nbad;

`ifdef LMFE_BORDER_REPLICATE_EN
        vt[0] = '{0, 0, 0, 8'h40};
        vt[1] = '{0, 0, 7, 8'h40};
        vt[2] = '{0, 7, 0, 8'h40};
        vt[3] = '{0, 7, 7, 8'h40};
`else
        vt[0] = '{0, 0, 0, 8'h00};
        vt[1] = '{0, 0, 7, 8'h00};
        vt[2] = '{0, 7, 7, 8'h00};
        vt[3] = '{0, 3, 0, 8'h40};
`endif
        vt[4] = '{0, 0, 3, 8'h40};
        vt[5] = '{0, 3, 3, 8'h40};
        vt[6] = '{0, 4, 4, 8'h40};
        vt[7] = '{1, 3, 3, 8'd27};
        vt[8] = '{1, 4, 4, 8'd36};
        vt[9] = '{1, 3, 4, 8'd28};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        #1 RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sen", 32'(sen), 32'd1);

        // Abort a frame mid-FILL with an asynchronous reset.
        set_img(1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_sen", 32'(sen), 32'd1);
        chk("rst_ins", 32'(ins), 32'hFF);
        chk("rst_del", 32'(del), 32'hFF);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk) RST = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_write_after_rst", 32'(nwrites), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Ramp frame straight after reset: pair stream checks.
        clear_stats();
        run_frame(1, 1'b0);
        chk("ramp_writes", 32'(nwrites), 32'd64);
        chk("ramp_done", 32'(ndone), 32'd1);
        chk("ramp_pairs", 32'(pdel.size()), 32'd784);
        chk("ramp_reads", 32'(nreads), 32'(exp_reads()));
        if (pdel.size() == 784) begin
            nbad = 0;
            for (int i = 0; i < 49; i++) if (pdel[i] !== 8'hFF) nbad++;
            chk("first_fill_del_ff", 32'(nbad), 32'd0);
            nbad = 0;
            for (int dr = 0; dr < 7; dr++) begin
                if (pdel[49 + dr] !== pix_at(dr - 3, -3)) nbad++;
                if (pins[49 + dr] !== pix_at(dr - 3, 4)) nbad++;
            end
            chk("slide_col1_pairs", 32'(nbad), 32'd0);
            for (int v = 0; v < 256; v++) begin
                ha[v] = 0;
                hb[v] = 0;
            end
            for (int i = 98; i < 147; i++) ha[pdel[i]]++;
            for (int dc = 0; dc < 7; dc++)
                for (int dr = 0; dr < 7; dr++) hb[pix_at(dr - 3, 4 + dc)]++;
            nbad = 0;
            for (int v = 0; v < 256; v++) if (ha[v] != hb[v]) nbad++;
            chk("row1_fill_del_set", 32'(nbad), 32'd0);
        end

        // Constant frame with start pulses while busy.
        set_img(0);
        clear_stats();
        run_frame(0, 1'b1);
        chk("const_writes", 32'(nwrites), 32'd64);
        chk("const_done", 32'(ndone), 32'd1);
        chk("frame_len", 32'(frame_len), 32'(8 * 53 + 8 * 7 * 11 + 1));
        repeat (20) @(negedge clk);
        chk("no_restart", 32'(busy), 32'd0);
        chk("engine_consistent", 32'(eng_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
